// File: rtl/switch_input_conditioner.sv
// switch_input_conditioner
//
// Conditions raw DIP-switch and pushbutton pins into clean signals for the top
// level. Every pin passes through a 2-flop synchroniser. The switch vector is
// debounced as one unit, so a change on any bit restarts the settle time for
// the whole vector. The active-low pushbutton is debounced the same way and
// then decoded into short and long press pulses.
//
// Parameters:
//   WIDTH        number of switch bits
//   DB_CYCLES    clk cycles an input must hold unchanged before it is committed
//   LONG_CYCLES  clk cycles a press must be held before it counts as long
//
// Ports:
//   clk          system clock
//   rstn         synchronous, active-low reset
//   sw_raw       asynchronous switch pins, 1 = switch on
//   btn_n        asynchronous pushbutton pin, 0 = pressed
//   sw_stable    debounced switch vector
//   sw_valid     high once sw_stable holds a committed value
//   sw_changed   1-cycle pulse when sw_stable takes a new value after the first commit
//   btn_level    debounced button state, 1 = pressed
//   short_press  1-cycle pulse on release of a short press
//   long_press   1-cycle pulse when a hold reaches LONG_CYCLES
//
// Build option:
//   BTN_LONGPRESS_EN  when defined, the press FSM has a hold counter and a HELD
//                     state and can emit long_press. When undefined, every
//                     release emits short_press and long_press is tied to 0.

module switch_input_conditioner #(
  parameter int WIDTH       = 4,
  parameter int DB_CYCLES   = 120000,
  parameter int LONG_CYCLES = 12000000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             btn_n,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_valid,
  output logic             sw_changed,
  output logic             btn_level,
  output logic             short_press,
  output logic             long_press
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

`ifdef BTN_LONGPRESS_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } press_state_t;

  localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_press_q, long_press_d;
`else
  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } press_state_t;
`endif

  // Synchronisers
  logic [WIDTH-1:0] sw_s1_q, sw_s1_d;
  logic [WIDTH-1:0] sw_s2_q, sw_s2_d;
  logic             btn_s1_q, btn_s1_d;
  logic             btn_s2_q, btn_s2_d;

  // Switch debounce
  logic [WIDTH-1:0] sw_cand_q, sw_cand_d;
  logic [DB_W-1:0]  sw_cnt_q, sw_cnt_d;
  logic [WIDTH-1:0] sw_stable_q, sw_stable_d;
  logic             sw_valid_q, sw_valid_d;
  logic             sw_changed_q, sw_changed_d;

  // Button debounce, candidate kept in pin polarity (1 = released)
  logic             btn_cand_q, btn_cand_d;
  logic [DB_W-1:0]  btn_cnt_q, btn_cnt_d;
  logic             btn_level_q, btn_level_d;

  // Press decoder
  press_state_t     state_q, state_d;
  logic             short_press_q, short_press_d;

  always_comb begin
    sw_s1_d  = sw_raw;
    sw_s2_d  = sw_s1_q;
    btn_s1_d = btn_n;
    btn_s2_d = btn_s1_q;
  end

  // The commit decision looks at the candidate and count as they stand this
  // cycle, so sw_stable follows cand one edge after the count saturates.
  // sw_changed is suppressed on the first commit after reset, which only
  // raises sw_valid.
  always_comb begin
    sw_cand_d    = sw_cand_q;
    sw_cnt_d     = sw_cnt_q;
    sw_stable_d  = sw_stable_q;
    sw_valid_d   = sw_valid_q;
    sw_changed_d = 1'b0;

    if (sw_s2_q != sw_cand_q) begin
      sw_cand_d = sw_s2_q;
      sw_cnt_d  = '0;
    end else if (sw_cnt_q != DB_MAX) begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end

    if ((sw_cnt_q == DB_MAX) && (!sw_valid_q || (sw_cand_q != sw_stable_q))) begin
      sw_stable_d  = sw_cand_q;
      sw_valid_d   = 1'b1;
      sw_changed_d = sw_valid_q;
    end
  end

  // Button level is the inverse of the candidate; a commit is needed only
  // when the level disagrees with the settled pin value.
  always_comb begin
    btn_cand_d  = btn_cand_q;
    btn_cnt_d   = btn_cnt_q;
    btn_level_d = btn_level_q;

    if (btn_s2_q != btn_cand_q) begin
      btn_cand_d = btn_s2_q;
      btn_cnt_d  = '0;
    end else if (btn_cnt_q != DB_MAX) begin
      btn_cnt_d = btn_cnt_q + 1'b1;
    end

    if ((btn_cnt_q == DB_MAX) && (btn_level_q == btn_cand_q)) begin
      btn_level_d = ~btn_cand_q;
    end
  end

  // Release is tested before the long threshold so a release on the same
  // cycle as the threshold produces only short_press.
  always_comb begin
    state_d       = state_q;
    short_press_d = 1'b0;
`ifdef BTN_LONGPRESS_EN
    hold_cnt_d    = hold_cnt_q;
    long_press_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (btn_level_q) begin
          state_d = PRESSED;
`ifdef BTN_LONGPRESS_EN
          hold_cnt_d = '0;
`endif
        end
      end
      PRESSED: begin
        if (!btn_level_q) begin
          state_d       = IDLE;
          short_press_d = 1'b1;
        end
`ifdef BTN_LONGPRESS_EN
        else if (hold_cnt_q == HOLD_MAX) begin
          state_d      = HELD;
          long_press_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end
`ifdef BTN_LONGPRESS_EN
      HELD: begin
        if (!btn_level_q) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sw_s1_q       <= '0;
      sw_s2_q       <= '0;
      btn_s1_q      <= 1'b1;
      btn_s2_q      <= 1'b1;
      sw_cand_q     <= '0;
      sw_cnt_q      <= '0;
      sw_stable_q   <= '0;
      sw_valid_q    <= 1'b0;
      sw_changed_q  <= 1'b0;
      btn_cand_q    <= 1'b1;
      btn_cnt_q     <= '0;
      btn_level_q   <= 1'b0;
      state_q       <= IDLE;
      short_press_q <= 1'b0;
`ifdef BTN_LONGPRESS_EN
      hold_cnt_q    <= '0;
      long_press_q  <= 1'b0;
`endif
    end else begin
      sw_s1_q       <= sw_s1_d;
      sw_s2_q       <= sw_s2_d;
      btn_s1_q      <= btn_s1_d;
      btn_s2_q      <= btn_s2_d;
      sw_cand_q     <= sw_cand_d;
      sw_cnt_q      <= sw_cnt_d;
      sw_stable_q   <= sw_stable_d;
      sw_valid_q    <= sw_valid_d;
      sw_changed_q  <= sw_changed_d;
      btn_cand_q    <= btn_cand_d;
      btn_cnt_q     <= btn_cnt_d;
      btn_level_q   <= btn_level_d;
      state_q       <= state_d;
      short_press_q <= short_press_d;
`ifdef BTN_LONGPRESS_EN
      hold_cnt_q    <= hold_cnt_d;
      long_press_q  <= long_press_d;
`endif
    end
  end

  assign sw_stable   = sw_stable_q;
  assign sw_valid    = sw_valid_q;
  assign sw_changed  = sw_changed_q;
  assign btn_level   = btn_level_q;
  assign short_press = short_press_q;
`ifdef BTN_LONGPRESS_EN
  assign long_press  = long_press_q;
`else
  assign long_press  = 1'b0;
`endif

endmodule

// File: tb/tb_switch_input_conditioner.sv
// tb_switch_input_conditioner
//
// Drives directed scenarios followed by randomized switch/button/reset
// activity. A reference model built from sampled-input history predicts every
// output each cycle; a handful of literal checks pin exact latencies and pulse
// counts.

module tb_switch_input_conditioner;

  localparam int WIDTH = 4;
  localparam int DB    = 8;
  localparam int LONG  = 32;
  localparam int MAXE  = 32768;

  logic             clk = 1'b0;
  logic             rstn;
  logic [WIDTH-1:0] sw_raw;
  logic             btn_n;
  logic [WIDTH-1:0] sw_stable;
  logic             sw_valid;
  logic             sw_changed;
  logic             btn_level;
  logic             short_press;
  logic             long_press;

  int total = 0;
  int bad   = 0;

  switch_input_conditioner #(
    .WIDTH(WIDTH),
    .DB_CYCLES(DB),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .sw_raw(sw_raw),
    .btn_n(btn_n),
    .sw_stable(sw_stable),
    .sw_valid(sw_valid),
    .sw_changed(sw_changed),
    .btn_level(btn_level),
    .short_press(short_press),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Reference model: rh/bh hold the raw values seen at edges 1..e since the
  // last reset edge (edge 0). The debounce candidate at edge x is the raw
  // value from two edges earlier; a value commits one edge after it has been
  // unchanged for DB consecutive edges since reset.
  logic [WIDTH-1:0] rh [0:MAXE-1];
  bit               bh [0:MAXE-1];
  int               e           = 0;
  bit               model_ready = 0;
  logic [WIDTH-1:0] m_stable;
  logic             m_valid, m_changed, m_level, m_short, m_long;
  int               press_start;
  bit               held;

  function automatic logic [WIDTH-1:0] swCand(int x);
    if (x >= 3) return rh[x-2];
    return '0;
  endfunction

  function automatic bit btnCand(int x);
    if (x >= 3) return bh[x-2];
    return 1'b0;
  endfunction

  function automatic bit swSettled(int x);
    if (x < DB - 1) return 1'b0;
    for (int y = x - DB + 2; y <= x; y++)
      if (swCand(y) !== swCand(y-1)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit btnSettled(int x);
    if (x < DB - 1) return 1'b0;
    for (int y = x - DB + 2; y <= x; y++)
      if (btnCand(y) != btnCand(y-1)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      e = 0;
      m_stable = '0; m_valid = 0; m_changed = 0;
      m_level = 0; m_short = 0; m_long = 0;
      press_start = -1; held = 0;
      model_ready = 1;
    end else if (model_ready && e < MAXE - 1) begin
      e++;
      rh[e] = sw_raw;
      bh[e] = ~btn_n;

      // press decoding uses the level that was visible before this edge
      m_short = 0;
      m_long  = 0;
      if (press_start < 0) begin
        if (m_level) press_start = e;
      end else if (!held) begin
        if (!m_level) begin
          m_short = 1;
          press_start = -1;
        end
`ifdef BTN_LONGPRESS_EN
        else if ((e - 1) - press_start == LONG - 1) begin
          m_long = 1;
          held = 1;
        end
`endif
      end else if (!m_level) begin
        press_start = -1;
        held = 0;
      end

      if (btnSettled(e-1)) m_level = btnCand(e-1);

      m_changed = 0;
      if (swSettled(e-1) && (!m_valid || swCand(e-1) !== m_stable)) begin
        m_changed = m_valid;
        m_stable  = swCand(e-1);
        m_valid   = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("sw_stable",   32'(sw_stable),   32'(m_stable));
      checkOutput("sw_valid",    32'(sw_valid),    32'(m_valid));
      checkOutput("sw_changed",  32'(sw_changed),  32'(m_changed));
      checkOutput("btn_level",   32'(btn_level),   32'(m_level));
      checkOutput("short_press", 32'(short_press), 32'(m_short));
      checkOutput("long_press",  32'(long_press),  32'(m_long));
    end
  end

  // Pulse counters for the literal pulse-count checks
  int n_changed = 0, n_short = 0, n_long = 0;
  always @(negedge clk) begin
    if (sw_changed)  n_changed++;
    if (short_press) n_short++;
    if (long_press)  n_long++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [WIDTH-1:0] sw, input logic b, input int cycles);
    rstn   = r;
    sw_raw = sw;
    btn_n  = b;
    repeat (cycles) tick();
  endtask

  initial begin
    int c0, s0, l0;
    logic [WIDTH-1:0] sw;
    logic r, b;
    int dur;

    rstn = 1'b0; sw_raw = '0; btn_n = 1'b1;

    // 1: reset with 0101 on the pins, first commit after 11 edges
    applyStimulus(1'b0, 4'b0101, 1'b1, 3);
    checkOutput("t1_rst_valid", 32'(sw_valid), 32'd0);
    checkOutput("t1_rst_stable", 32'(sw_stable), 32'd0);
    checkOutput("t1_rst_level", 32'(btn_level), 32'd0);
    c0 = n_changed;
    applyStimulus(1'b1, 4'b0101, 1'b1, 10);
    checkOutput("t1_valid_e10", 32'(sw_valid), 32'd0);
    tick();
    checkOutput("t1_valid_e11", 32'(sw_valid), 32'd1);
    checkOutput("t1_stable_e11", 32'(sw_stable), 32'h5);
    checkOutput("t1_changed_e11", 32'(sw_changed), 32'd0);
    repeat (5) tick();
    checkOutput("t1_changed_cnt", 32'(n_changed - c0), 32'd0);

    // 2: bounce bit0 every 5 cycles, then settle on 0100
    c0 = n_changed;
    sw = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      sw[0] = ~sw[0];
      applyStimulus(1'b1, sw, 1'b1, 5);
    end
    checkOutput("t2_stable_bounce", 32'(sw_stable), 32'h5);
    applyStimulus(1'b1, 4'b0100, 1'b1, 10);
    checkOutput("t2_stable_e9", 32'(sw_stable), 32'h5);
    tick();
    checkOutput("t2_stable_e10", 32'(sw_stable), 32'h4);
    checkOutput("t2_changed_e10", 32'(sw_changed), 32'd1);
    repeat (10) tick();
    checkOutput("t2_changed_cnt", 32'(n_changed - c0), 32'd1);

    // 3: short press of 15 cycles
    s0 = n_short; l0 = n_long;
    applyStimulus(1'b1, 4'b0100, 1'b0, 10);
    checkOutput("t3_level_e9", 32'(btn_level), 32'd0);
    tick();
    checkOutput("t3_level_e10", 32'(btn_level), 32'd1);
    repeat (4) tick();
    applyStimulus(1'b1, 4'b0100, 1'b1, 11);
    checkOutput("t3_level_rel", 32'(btn_level), 32'd0);
    tick();
    checkOutput("t3_short_e26", 32'(short_press), 32'd1);
    repeat (10) tick();
    checkOutput("t3_short_cnt", 32'(n_short - s0), 32'd1);
    checkOutput("t3_long_cnt", 32'(n_long - l0), 32'd0);

    // 4: long hold of 60 cycles
    s0 = n_short; l0 = n_long;
    applyStimulus(1'b1, 4'b0100, 1'b0, 43);
    checkOutput("t4_long_e42", 32'(long_press), 32'd0);
    tick();
`ifdef BTN_LONGPRESS_EN
    checkOutput("t4_long_e43", 32'(long_press), 32'd1);
`else
    checkOutput("t4_long_e43", 32'(long_press), 32'd0);
`endif
    repeat (16) tick();
    applyStimulus(1'b1, 4'b0100, 1'b1, 20);
`ifdef BTN_LONGPRESS_EN
    checkOutput("t4_long_cnt", 32'(n_long - l0), 32'd1);
    checkOutput("t4_short_cnt", 32'(n_short - s0), 32'd0);
`else
    checkOutput("t4_long_cnt", 32'(n_long - l0), 32'd0);
    checkOutput("t4_short_cnt", 32'(n_short - s0), 32'd1);
`endif

    // 5: 3-cycle glitch is filtered
    s0 = n_short; l0 = n_long;
    applyStimulus(1'b1, 4'b0100, 1'b0, 3);
    applyStimulus(1'b1, 4'b0100, 1'b1, 15);
    checkOutput("t5_level", 32'(btn_level), 32'd0);
    checkOutput("t5_pulses", 32'((n_short - s0) + (n_long - l0)), 32'd0);

    // 6: reset in the middle of a hold
    s0 = n_short; l0 = n_long; c0 = n_changed;
    applyStimulus(1'b1, 4'b0100, 1'b0, 20);
    checkOutput("t6_level_held", 32'(btn_level), 32'd1);
    applyStimulus(1'b0, 4'b0100, 1'b0, 1);
    checkOutput("t6_rst_valid", 32'(sw_valid), 32'd0);
    checkOutput("t6_rst_stable", 32'(sw_stable), 32'd0);
    checkOutput("t6_rst_level", 32'(btn_level), 32'd0);
    checkOutput("t6_rst_short", 32'(short_press), 32'd0);
    checkOutput("t6_rst_long", 32'(long_press), 32'd0);
    applyStimulus(1'b1, 4'b0100, 1'b1, 40);
    checkOutput("t6_pulses", 32'((n_short - s0) + (n_long - l0)), 32'd0);
    checkOutput("t6_changed", 32'(n_changed - c0), 32'd0);
    checkOutput("t6_valid_again", 32'(sw_valid), 32'd1);

    // Randomized phase: switch changes, presses of mixed length, sparse resets
    sw = 4'b0100; b = 1'b1;
    for (int i = 0; i < 200; i++) begin
      r = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 2) == 0) sw = WIDTH'($urandom);
      if ($urandom_range(0, 1) == 0) b = ~b;
      dur = r ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 2));
      applyStimulus(r, sw, b, dur);
    end
    applyStimulus(1'b1, sw, 1'b1, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
